stump_control: RTL and testbench
================================

// Module: stump_control
// PURPOSE
//  Stump processor sequencer: the producer side of the ALU interface. Walks FETCH/EXECUTE/MEMORY,
//  decodes the instruction register and drives ALU func/c_in, operand selects, register and PC
//  write enables and the memory request handshake. Owns the registered NZVC condition-code register.
//  It does not perform datapath arithmetic; the datapath consumes every output.
// PARAMETERS
//  CC_RESET   4'b0000   value loaded into cc_out on reset ({N,Z,V,C})
// PORTS
//  clk         in   1   single system clock, all state changes on rising edge
//  rst         in   1   synchronous, active-high reset
//  ir          in   16  instruction register contents, valid from EXECUTE onward
//  alu_flags   in   4   {N,Z,V,C} from ALU, sampled in EXECUTE
//  mem_ready   in   1   memory completes the current request this cycle
//  state       out  2   00 FETCH, 01 EXECUTE, 10 MEMORY (11 unused)
//  mem_req     out  1   memory access request, held until mem_ready
//  mem_wen     out  1   1 = store, valid only while mem_req=1
//  ir_load     out  1   datapath latches memory data into IR
//  pc_write    out  1   datapath writes PC (increment in FETCH, target in EXECUTE)
//  reg_write   out  1   register-file write enable
//  reg_dst     out  3   destination register = ir[10:8]
//  alu_func    out  3   ALU function select
//  alu_c_in    out  1   ALU carry in
//  opb_imm     out  1   1 = operand B is sign-extended immediate
//  shift_op    out  2   shifter control = ir[1:0] for type-0, else 00
//  cc_out      out  4   registered {N,Z,V,C}
// BEHAVIOUR
//  Reset: state=FETCH, cc_out=CC_RESET; all other outputs 0. Reset mid-access drops mem_req the next
//   edge; no register/PC write occurs in that cycle. Reset dominates every other event.
//  Encoding: op=ir[15:13], type=ir[12], S=ir[11]. ALU ops 000..101; 110 LD/ST (ir[11]=1 load);
//   111 Bcc, cond=ir[11:8].
//  FETCH: mem_req=1, mem_wen=0. Held while mem_ready=0 (indefinitely). On the mem_ready cycle:
//   ir_load=1, pc_write=1 (PC+1), next=EXECUTE. Minimum latency per instruction = 2 cycles.
//  EXECUTE, ALU op: alu_func=op, opb_imm=type, reg_write=1, next=FETCH.
//   alu_c_in=cc_out[0] for ADC(001)/SBC(011), else 0.
//   If S=1: cc_out<=alu_flags on this edge. If S=0: cc unchanged.
//  EXECUTE, LD/ST: alu_func=000 (address = A+B/imm), opb_imm=type, no reg_write, next=MEMORY.
//  EXECUTE, Bcc: alu_func=000, opb_imm=1. If cond true: pc_write=1 (PC+offset). No reg_write.
//   Never updates cc. Next=FETCH.
//  MEMORY: mem_req=1, mem_wen=~ir[11]; held until mem_ready. On mem_ready: reg_write=1 if load.
//   Next=FETCH.
//  mem_ready while mem_req=0 is ignored.
//  State 11 is never entered; if reached, next=FETCH with all enables 0.
//  Conditions use cc_out, i.e. the registered flags from a previous S=1 op:
//   0 AL:1                 1 NV:0
//   2 HI:~C&~Z             3 LS:C|Z
//   4 CC:~C                5 CS:C
//   6 NE:~Z                7 EQ:Z
//   8 VC:~V                9 VS:V
//   A PL:~N                B MI:N
//   C GE:N==V              D LT:N!=V
//   E GT:~Z&(N==V)         F LE:Z|(N!=V)
//  Outputs are Moore-style from state+ir, except that the handshake-completion enables also depend
//   on mem_ready: ir_load and pc_write in FETCH, reg_write in MEMORY.
// STRUCTURE
//  stump_pkg: state encodings; opcode constants (ADD..BCC); condition-code constants; flag bit indices
//   N=3, Z=2, V=1, C=0.
//  One combinational sub-module, stump_cond_eval(cond[3:0], cc[3:0]) -> taken. The rest is one FSM
//   plus the cc register.
// TESTING
//  1. rst=1 mid-MEMORY (mem_req=1) -> next cycle state=00, mem_req=0, cc_out=CC_RESET, reg_write=0.
//  2. FETCH, mem_ready low 3 cycles then high -> mem_req high 4 cycles; ir_load=pc_write=1 on 4th
//     cycle only; state 01.
//  3. ir=16'h0800 (ADD S=1), alu_flags=4'b0100 -> reg_write=1, alu_func=000, cc_out=0100 after edge.
//     Same with S=0 -> cc unchanged.
//  4. cc_out=0001, ir=ADC (op 001) -> alu_c_in=1; with SBC and cc_out=0000 -> alu_c_in=0.
//  5. Bcc sweep, all 16 conds x all 16 cc values, checked against the condition table
//     -> pc_write matches taken; reg_write=0; cc unchanged.
//  6. LD ir=16'hC800 -> EXECUTE alu_func=000; MEMORY mem_wen=0, reg_write only on mem_ready.
//     ST ir=16'hC000 -> mem_wen=1, reg_write=0.

Source files
------------

// File: rtl/stump_control_pkg.sv
// stump_control_pkg: shared state, opcode, condition and flag-index constants for the Stump sequencer.
package stump_control_pkg;
  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC  = 2'b01;
  localparam logic [1:0] S_MEM   = 2'b10;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;
  localparam logic [3:0] C_AL = 4'h0, C_NV = 4'h1, C_HI = 4'h2, C_LS = 4'h3;
  localparam logic [3:0] C_CC = 4'h4, C_CS = 4'h5, C_NE = 4'h6, C_EQ = 4'h7;
  localparam logic [3:0] C_VC = 4'h8, C_VS = 4'h9, C_PL = 4'hA, C_MI = 4'hB;
  localparam logic [3:0] C_GE = 4'hC, C_LT = 4'hD, C_GT = 4'hE, C_LE = 4'hF;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_V = 1;
  localparam int F_C = 0;
endpackage

// File: rtl/stump_control_if.sv
// stump_control_if: sequencer <-> datapath/memory signal bundle; the sequencer is the master.
interface stump_control_if;
  logic [15:0] ir;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic [1:0]  state;
  logic        mem_req;
  logic        mem_wen;
  logic        ir_load;
  logic        pc_write;
  logic        reg_write;
  logic [2:0]  reg_dst;
  logic [2:0]  alu_func;
  logic        alu_c_in;
  logic        opb_imm;
  logic [1:0]  shift_op;
  logic [3:0]  cc_out;
  modport master (
    input  ir, alu_flags, mem_ready,
    output state, mem_req, mem_wen, ir_load, pc_write, reg_write, reg_dst,
           alu_func, alu_c_in, opb_imm, shift_op, cc_out
  );
  modport slave (
    output ir, alu_flags, mem_ready,
    input  state, mem_req, mem_wen, ir_load, pc_write, reg_write, reg_dst,
           alu_func, alu_c_in, opb_imm, shift_op, cc_out
  );
endinterface

// File: rtl/stump_control_cond_eval.sv
// stump_cond_eval: branch condition evaluation; odd conditions are the complement of the even one below.
module stump_cond_eval
  import stump_control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);
  logic n, z, v, c;
  logic [7:0] base;
  assign {n, z, v, c} = {cc[F_N], cc[F_Z], cc[F_V], cc[F_C]};
  assign base = {~z & (n == v), n == v, ~n, ~v, ~z, ~c, ~c & ~z, 1'b1};
  assign taken = base[cond[3:1]] ^ cond[0];
endmodule

// File: rtl/stump_control.sv
// stump_control: FETCH/EXECUTE/MEMORY sequencer driving the Stump datapath, plus the NZVC register.
module stump_control
  import stump_control_pkg::*;
#(
  parameter logic [3:0] CC_RESET = 4'b0000
) (
  input logic           clk,
  input logic           rst,
  stump_control_if.master bus
);
  logic [1:0] state_q, state_d;
  logic [3:0] cc_q, cc_d;
  logic [2:0] op;
  logic       is_alu, taken;
  assign op = bus.ir[15:13];
  assign is_alu = ~(op[2] & op[1]);
  stump_cond_eval u_cond (.cond(bus.ir[11:8]), .cc(cc_q), .taken(taken));
  // Reset gates every enable combinationally so an access interrupted by rst commits nothing.
  always_comb begin
    state_d = S_FETCH;
    cc_d = cc_q;
    bus.mem_req = 1'b0;
    bus.mem_wen = 1'b0;
    bus.ir_load = 1'b0;
    bus.pc_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 3'b000;
    bus.alu_func = 3'b000;
    bus.alu_c_in = 1'b0;
    bus.opb_imm = 1'b0;
    bus.shift_op = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_load = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
          state_d = bus.mem_ready ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          bus.reg_dst = bus.ir[10:8];
          bus.alu_func = is_alu ? op : 3'b000;
          bus.opb_imm = (op == OP_BCC) ? 1'b1 : bus.ir[12];
          bus.alu_c_in = is_alu & (op == OP_ADC || op == OP_SBC) & cc_q[F_C];
          bus.shift_op = (is_alu && !bus.ir[12]) ? bus.ir[1:0] : 2'b00;
          bus.reg_write = is_alu;
          bus.pc_write = (op == OP_BCC) & taken;
          cc_d = (is_alu && bus.ir[11]) ? bus.alu_flags : cc_q;
          state_d = (op == OP_LDST) ? S_MEM : S_FETCH;
        end
        S_MEM: begin
          bus.reg_dst = bus.ir[10:8];
          bus.mem_req = 1'b1;
          bus.mem_wen = ~bus.ir[11];
          bus.reg_write = bus.mem_ready & bus.ir[11];
          state_d = bus.mem_ready ? S_FETCH : S_MEM;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cc_q <= CC_RESET;
    end else begin
      state_q <= state_d;
      cc_q <= cc_d;
    end
  end
  assign bus.state = state_q;
  assign bus.cc_out = cc_q;
endmodule

// File: tb/tb_stump_control.sv
// tb_stump_control: directed vectors against hand-derived expectations for the Stump sequencer.
module tb_stump_control;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  stump_control_if bus ();
  stump_control #(.CC_RESET(4'b0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [15:0] v);
    bus.mem_ready = 1'b1;
    bus.ir = v;
    tick();
    bus.mem_ready = 1'b0;
  endtask
  task automatic set_cc(input logic [3:0] f);
    fetch(16'h0800);
    bus.alu_flags = f;
    tick();
  endtask
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] cc);
    logic n, z, v, cy;
    {n, z, v, cy} = cc;
    case (c)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return ~cy & ~z;
      4'h3: return cy | z;
      4'h4: return ~cy;
      4'h5: return cy;
      4'h6: return ~z;
      4'h7: return z;
      4'h8: return ~v;
      4'h9: return v;
      4'hA: return ~n;
      4'hB: return n;
      4'hC: return n == v;
      4'hD: return n != v;
      4'hE: return ~z & (n == v);
      default: return z | (n != v);
    endcase
  endfunction
  initial begin
    rst = 1'b1;
    bus.ir = 16'h0000;
    bus.alu_flags = 4'h0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", 16'(bus.state), 16'h0);
    chk("rst_cc", 16'(bus.cc_out), 16'h0);
    chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fetch_wait_req", 16'(bus.mem_req), 16'h1);
      chk("fetch_wait_ld", 16'({bus.ir_load, bus.pc_write}), 16'h0);
      tick();
      chk("fetch_wait_state", 16'(bus.state), 16'h0);
    end
    bus.mem_ready = 1'b1;
    bus.ir = 16'h0800;
    #1;
    chk("fetch_done_req", 16'(bus.mem_req), 16'h1);
    chk("fetch_done_ld", 16'({bus.ir_load, bus.pc_write}), 16'h3);
    tick();
    bus.mem_ready = 1'b0;
    chk("exec_state", 16'(bus.state), 16'h1);
    bus.alu_flags = 4'b0100;
    #1;
    chk("add_s_rw", 16'(bus.reg_write), 16'h1);
    chk("add_s_func", 16'(bus.alu_func), 16'h0);
    chk("add_s_pc", 16'(bus.pc_write), 16'h0);
    tick();
    chk("add_s_cc", 16'(bus.cc_out), 16'h4);
    chk("add_s_next", 16'(bus.state), 16'h0);
    fetch(16'h0503);
    bus.alu_flags = 4'b1111;
    #1;
    chk("add_ns_dst", 16'(bus.reg_dst), 16'h5);
    chk("add_ns_shift", 16'(bus.shift_op), 16'h3);
    tick();
    chk("add_ns_cc", 16'(bus.cc_out), 16'h4);
    set_cc(4'b0001);
    fetch(16'h2000);
    #1;
    chk("adc_cin", 16'(bus.alu_c_in), 16'h1);
    chk("adc_func", 16'(bus.alu_func), 16'h1);
    tick();
    fetch(16'h5000);
    #1;
    chk("sub_cin", 16'(bus.alu_c_in), 16'h0);
    chk("sub_imm", 16'({bus.opb_imm, bus.shift_op}), 16'h4);
    tick();
    set_cc(4'b0000);
    fetch(16'h6000);
    #1;
    chk("sbc_cin", 16'(bus.alu_c_in), 16'h0);
    tick();
    for (int c = 0; c < 16; c++) begin
      set_cc(4'(c));
      for (int k = 0; k < 16; k++) begin
        fetch(16'hE000 | 16'(k << 8));
        bus.alu_flags = ~4'(c);
        #1;
        chk($sformatf("bcc_%0h_cc%0h_pc", k, c), 16'(bus.pc_write), 16'(cond_model(4'(k), 4'(c))));
        chk("bcc_rw", 16'({bus.reg_write, bus.opb_imm}), 16'h1);
        tick();
        chk("bcc_cc", 16'(bus.cc_out), 16'(c));
      end
    end
    fetch(16'hC800);
    #1;
    chk("ld_func", 16'(bus.alu_func), 16'h0);
    chk("ld_exec_rw", 16'(bus.reg_write), 16'h0);
    tick();
    chk("ld_state", 16'(bus.state), 16'h2);
    chk("ld_req_wen", 16'({bus.mem_req, bus.mem_wen}), 16'h2);
    chk("ld_wait_rw", 16'(bus.reg_write), 16'h0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("ld_done_rw", 16'(bus.reg_write), 16'h1);
    tick();
    bus.mem_ready = 1'b0;
    chk("ld_next", 16'(bus.state), 16'h0);
    fetch(16'hC000);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("st_req_wen", 16'({bus.mem_req, bus.mem_wen}), 16'h3);
    chk("st_rw", 16'(bus.reg_write), 16'h0);
    tick();
    bus.mem_ready = 1'b0;
    chk("st_next", 16'(bus.state), 16'h0);
    fetch(16'hC800);
    tick();
    chk("rst_mid_state", 16'(bus.state), 16'h2);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_mid_rw", 16'({bus.reg_write, bus.pc_write}), 16'h0);
    tick();
    bus.mem_ready = 1'b0;
    chk("rst_mid_next", 16'(bus.state), 16'h0);
    chk("rst_mid_req", 16'(bus.mem_req), 16'h0);
    chk("rst_mid_cc", 16'(bus.cc_out), 16'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 16'(bus.mem_req), 16'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
